// File: rtl/stack_arbiter_if.sv
// Requester-side bundle of the stack arbiter: op requests in, grant/completion out.
interface stack_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [1:0]            req;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] wdata_0;
  logic [DATA_WIDTH-1:0] wdata_1;
  logic [1:0]            gnt;
  logic [1:0]            done;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output req, op, wdata_0, wdata_1,
    input  gnt, done, rdata, err, count
  );

  modport slave (
    input  req, op, wdata_0, wdata_1,
    output gnt, done, rdata, err, count
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin sharing of one LIFO stack between two requesters, with registered completions.
// Optional: define STACK_ARB_ERR_EN to grant illegal ops and complete them with err=1.
module stack_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  stack_arbiter_if.slave        bus,
  output logic                  stk_push,
  output logic [DATA_WIDTH-1:0] stk_wr_data,
  input  logic                  stk_full,
  output logic                  stk_pop,
  input  logic [DATA_WIDTH-1:0] stk_rd_data,
  input  logic                  stk_empty
);

  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic       ptr;        // 0: r0 wins a tie, 1: r1 wins a tie
  logic [1:0] legal;
  logic [1:0] elig;
  logic       any_gnt;
  logic       sel;
  logic       sel_op;
  logic       sel_legal;

  // An op is legal when the stack can serve it right now.
  always_comb begin
    legal = 2'b00;
    elig  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      legal[i] = bus.op[i] ? !stk_empty : !stk_full;
`ifdef STACK_ARB_ERR_EN
      elig[i]  = bus.req[i] & !rst;
`else
      elig[i]  = bus.req[i] & legal[i] & !rst;
`endif
    end
  end

  always_comb begin
    bus.gnt = 2'b00;
    if (elig == 2'b11) begin
      bus.gnt = ptr ? 2'b10 : 2'b01;
    end else begin
      bus.gnt = elig;
    end
  end

  always_comb begin
    any_gnt     = |bus.gnt;
    sel         = bus.gnt[1];
    sel_op      = bus.op[sel];
    sel_legal   = legal[sel];
    stk_push    = any_gnt & !sel_op & sel_legal;
    stk_pop     = any_gnt &  sel_op & sel_legal;
    stk_wr_data = sel ? bus.wdata_1 : bus.wdata_0;
  end

  // Completion, pop data, occupancy and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 1'b0;
      bus.done  <= 2'b00;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
      bus.count <= '0;
    end else begin
      bus.done <= bus.gnt;
`ifdef STACK_ARB_ERR_EN
      bus.err  <= any_gnt & !sel_legal;
`else
      bus.err  <= 1'b0;
`endif
      if (any_gnt) begin
        ptr <= !sel;
      end
      if (stk_pop) begin
        bus.rdata <= stk_rd_data;
      end
      if (stk_push && bus.count != CW'(DEPTH)) begin
        bus.count <= bus.count + CW'(1);
      end else if (stk_pop && bus.count != CW'(0)) begin
        bus.count <= bus.count - CW'(1);
      end
    end
  end

endmodule
